// File: rtl/sobel_window_buffer.sv
// Raster-order pixel stream to 3x3 neighbourhood buffer for a Sobel stage.
// A shifting line store emits a registered window for every interior pixel of a frame.
module sobel_window_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                     clk_i,
  input  logic                     nreset_i,
  input  logic                     start_i,
  input  logic                     px_rdy_i,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel_i,
  output logic [9*PIXEL_WIDTH-1:0] window_o,
  output logic                     win_rdy_o,
  output logic                     frame_done_o,
  output logic                     busy_o
);

  localparam int DEPTH = 2 * IMG_WIDTH + 3;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [PIXEL_WIDTH-1:0]  sr      [DEPTH];
  logic [PIXEL_WIDTH-1:0]  sr_next [DEPTH];
  logic [9*PIXEL_WIDTH-1:0] window_next;
  logic                    accept;
  logic                    last_px;
  logic                    emit;

  // start_i wins over a coincident pixel, so the pixel is dropped
  assign accept  = (state == ACTIVE) && px_rdy_i && !start_i;
  assign last_px = (col == COL_LAST) && (row == ROW_LAST);
  assign emit    = accept && (col >= COL_TWO) && (row >= ROW_TWO);

  always_comb begin
    sr_next[0] = in_pixel_i;
    for (int k = 1; k < DEPTH; k++) begin
      sr_next[k] = sr[k-1];
    end
  end

  // The window is taken from the post-shift contents so it includes the incoming pixel
  always_comb begin
    window_next = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window_next[PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH] = sr_next[(2-r)*IMG_WIDTH + (2-c)];
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        sr[k] <= '0;
      end
      window_o     <= '0;
      win_rdy_o    <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      win_rdy_o    <= 1'b0;
      frame_done_o <= 1'b0;

      if (accept) begin
        for (int k = 0; k < DEPTH; k++) begin
          sr[k] <= sr_next[k];
        end
      end

      if (emit) begin
        window_o  <= window_next;
        win_rdy_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= ACTIVE;
            col    <= '0;
            row    <= '0;
            busy_o <= 1'b1;
          end
        end
        ACTIVE: begin
          if (start_i) begin
            col <= '0;
            row <= '0;
          end else if (px_rdy_i) begin
            if (last_px) begin
              state        <= DONE;
              col          <= '0;
              row          <= '0;
              frame_done_o <= 1'b1;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state <= ACTIVE;
            col   <= '0;
            row   <= '0;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 frame of pixel values 0..15.
// Expected windows come from hand-written constants and a row/column formula.
module tb_sobel_window_buffer;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  localparam logic [9*PW-1:0] FIRST_WIN = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [9*PW-1:0] LAST_WIN  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

  logic            clk      = 1'b0;
  logic            nreset   = 1'b0;
  logic            start    = 1'b0;
  logic            px_rdy   = 1'b0;
  logic [PW-1:0]   pixel    = '0;
  logic [9*PW-1:0] window;
  logic            win_rdy;
  logic            frame_done;
  logic            busy;

  int              vectors     = 0;
  int              miscompares = 0;
  int              dut_windows = 0;
  logic [9*PW-1:0] last_window = '0;
  logic [9*PW-1:0] first_win   = '0;

  always #5 clk = ~clk;

  sobel_window_buffer #(
    .PIXEL_WIDTH(PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .start_i     (start),
    .px_rdy_i    (px_rdy),
    .in_pixel_i  (pixel),
    .window_o    (window),
    .win_rdy_o   (win_rdy),
    .frame_done_o(frame_done),
    .busy_o      (busy)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [9*PW-1:0] obs, input logic [9*PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs are read 1 ns after the next edge
  task automatic apply_stimulus(input logic s, input logic r, input logic [PW-1:0] p);
    start  = s;
    px_rdy = r;
    pixel  = p;
    @(posedge clk);
    #1;
    start  = 1'b0;
    px_rdy = 1'b0;
  endtask

  function automatic logic [9*PW-1:0] exp_window(input int r, input int c);
    logic [9*PW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[PW*(3*i+j) +: PW] = PW'((r - 2 + i) * W + (c - 2 + j));
      end
    end
    return w;
  endfunction

  task automatic run_frame(input int max_gap);
    int   r;
    int   c;
    int   gap;
    logic want;
    dut_windows = 0;
    for (int idx = 0; idx < W*H; idx++) begin
      r = idx / W;
      c = idx % W;
      want = (r >= 2) && (c >= 2);
      apply_stimulus(1'b0, 1'b1, PW'(idx));
      check_bit("win_rdy", win_rdy, want);
      check_bit("frame_done", frame_done, idx == W*H-1);
      check_bit("busy", busy, 1'b1);
      if (win_rdy === 1'b1) begin
        dut_windows++;
        if (dut_windows == 1) first_win = window;
      end
      if (want) last_window = exp_window(r, c);
      check_output("window", window, last_window);
      if (idx != W*H-1) begin
        gap = $urandom_range(max_gap, 0);
        for (int g = 0; g < gap; g++) begin
          apply_stimulus(1'b0, 1'b0, 8'hEE);
          check_bit("gap_win_rdy", win_rdy, 1'b0);
          check_output("gap_window_hold", window, last_window);
        end
      end
    end
    check_output("first_window", first_win, FIRST_WIN);
    check_output("last_window", window, LAST_WIN);
    check_output("window_count", 72'(dut_windows), 72'd4);
  endtask

  task automatic end_frame();
    apply_stimulus(1'b0, 1'b0, '0);
    check_bit("idle_busy", busy, 1'b0);
    check_bit("idle_frame_done", frame_done, 1'b0);
    check_bit("idle_win_rdy", win_rdy, 1'b0);
    check_output("idle_window_hold", window, LAST_WIN);
  endtask

  task automatic start_frame();
    apply_stimulus(1'b1, 1'b0, '0);
    check_bit("start_busy", busy, 1'b1);
    check_bit("start_win_rdy", win_rdy, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    check_output("reset_window", window, '0);
    check_bit("reset_win_rdy", win_rdy, 1'b0);
    check_bit("reset_frame_done", frame_done, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0);
    check_bit("post_reset_win_rdy", win_rdy, 1'b0);
    check_bit("post_reset_busy", busy, 1'b0);

    $display("[TB] nominal frame");
    start_frame();
    run_frame(0);
    end_frame();

    $display("[TB] gapped frame");
    start_frame();
    run_frame(3);
    end_frame();

    $display("[TB] ignored input");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'd99);
      check_bit("idle_px_win_rdy", win_rdy, 1'b0);
      check_bit("idle_px_busy", busy, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, 8'd200);
    check_bit("start_with_px_busy", busy, 1'b1);
    check_bit("start_with_px_win_rdy", win_rdy, 1'b0);
    run_frame(0);
    end_frame();

    $display("[TB] restart mid-frame");
    start_frame();
    for (int idx = 0; idx <= 6; idx++) begin
      apply_stimulus(1'b0, 1'b1, PW'(idx));
      check_bit("partial_win_rdy", win_rdy, 1'b0);
    end
    apply_stimulus(1'b1, 1'b0, '0);
    check_bit("restart_busy", busy, 1'b1);
    check_bit("restart_win_rdy", win_rdy, 1'b0);
    run_frame(0);
    end_frame();

    $display("[TB] async reset mid-frame");
    start_frame();
    for (int idx = 0; idx <= 11; idx++) begin
      apply_stimulus(1'b0, 1'b1, PW'(idx));
    end
    check_bit("pre_reset_win_rdy", win_rdy, 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    check_output("async_reset_window", window, '0);
    check_bit("async_reset_win_rdy", win_rdy, 1'b0);
    check_bit("async_reset_frame_done", frame_done, 1'b0);
    check_bit("async_reset_busy", busy, 1'b0);
    last_window = '0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0);
    check_bit("release_win_rdy", win_rdy, 1'b0);
    check_bit("release_busy", busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'd5);
      check_bit("after_reset_px_busy", busy, 1'b0);
      check_bit("after_reset_px_win_rdy", win_rdy, 1'b0);
    end
    start_frame();
    run_frame(0);
    end_frame();

    $display("[TB] back-to-back frames");
    start_frame();
    run_frame(0);
    apply_stimulus(1'b1, 1'b0, '0);
    check_bit("b2b_busy", busy, 1'b1);
    check_bit("b2b_frame_done", frame_done, 1'b0);
    check_bit("b2b_win_rdy", win_rdy, 1'b0);
    run_frame(0);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

Interface
REQ-001 Parameter PIXEL_WIDTH, 8, grayscale pixel width in bits.
REQ-002 Parameter IMG_WIDTH, 16, pixels per image row; legal range 3 or more.
REQ-003 Parameter IMG_HEIGHT, 16, rows per frame; legal range 3 or more.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 nreset_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  frame start or restart request, sampled each cycle.
REQ-007 px_rdy_i  input  1  in_pixel_i valid this cycle; single-cycle strobe per pixel.
REQ-008 in_pixel_i  input  PIXEL_WIDTH  grayscale pixel, raster order.
REQ-009 window_o  output  9*PIXEL_WIDTH  3x3 neighbourhood, registered.
REQ-010 win_rdy_o  output  1  one-cycle pulse: window_o holds a new valid window.
REQ-011 frame_done_o  output  1  one-cycle pulse after the final pixel of a frame.
REQ-012 busy_o  output  1  high while the FSM is not IDLE.

Function
REQ-013 FSM states are IDLE, ACTIVE and DONE.
- IDLE -> ACTIVE on start_i.
- ACTIVE -> DONE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- DONE -> IDLE after one cycle, or DONE -> ACTIVE if start_i is high.
REQ-014 A pixel is accepted only when the state is ACTIVE, px_rdy_i=1 and start_i=0; px_rdy_i in IDLE or DONE is ignored.
REQ-015 start_i in ACTIVE (abort or restart) zeroes the column and row counters and keeps the state ACTIVE; the shift register is not cleared.
REQ-016 start_i and px_rdy_i in the same cycle: start wins and the pixel is dropped.
REQ-017 Column counter col counts 0..IMG_WIDTH-1 per accepted pixel. On wrap it returns to 0 and row increments; row counts 0..IMG_HEIGHT-1.
REQ-018 Counter widths are $clog2 of the respective dimension. Entering ACTIVE from IDLE or DONE zeroes both counters.
REQ-019 Pixel storage is a shift register of depth 2*IMG_WIDTH+3. sr[0] is the newest pixel. It shifts only on an accepted pixel.
REQ-020 Window element p(r,c), with r=0 the top row and c=0 the left column, equals sr[(2-r)*IMG_WIDTH+(2-c)]. It is packed at window_o[PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH].
REQ-021 When the pixel accepted at cycle t has row>=2 and col>=2, window_o is loaded (including that pixel) and win_rdy_o=1 at cycle t+1. Fixed latency is 1 cycle.
- The window centre is (row-1, col-1).
- No windows are emitted for border rows or columns; no padding.
REQ-022 Each frame emits exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
REQ-023 window_o holds its last value between pulses.
REQ-024 frame_done_o is high in the DONE cycle, i.e. coincident with the final win_rdy_o pulse.
REQ-025 Pixels may arrive back-to-back every cycle or with arbitrary gaps; output is identical in both cases.
REQ-026 busy_o=1 in ACTIVE and DONE.
REQ-027 There is no backpressure; the consumer must accept window_o on the pulse.

Reset
REQ-028 nreset_i low immediately forces all of the following:
- state IDLE;
- counters 0;
- shift register 0;
- window_o=0, win_rdy_o=0, frame_done_o=0, busy_o=0.
REQ-029 Reset mid-frame discards the partial frame; after release the block waits in IDLE for start_i.
REQ-030 No output pulse is generated during reset or in the first cycle after reset release.

Verification (bench parameters IMG_WIDTH=4, IMG_HEIGHT=4, PIXEL_WIDTH=8)
REQ-031 Nominal frame:
- Stimulus: start_i pulse, then pixels 0..15 back-to-back.
- First win_rdy_o occurs 1 cycle after pixel 10, with window {0,1,2,4,5,6,8,9,10} (p00..p22).
- Exactly 4 windows; the last is {5,6,7,9,10,11,13,14,15}.
- frame_done_o pulses with the last window, then busy_o falls.
REQ-032 Gapped input:
- Stimulus: same frame with 0-3 idle cycles between pixels.
- Window values and count are identical to REQ-031; every pulse is 1 cycle after its triggering pixel.
REQ-033 Ignored input:
- Stimulus: px_rdy_i pulses in IDLE, and px_rdy_i together with start_i.
- No counter advance and no win_rdy_o; the following frame matches REQ-031.
REQ-034 Restart mid-frame:
- Stimulus: start_i after pixel 6, then pixels 0..15.
- The first window is {0,1,2,4,5,6,8,9,10}, and there are 4 windows total.
REQ-035 Async reset mid-frame:
- Stimulus: assert nreset_i after pixel 11.
- All outputs are 0 immediately; the block stays IDLE; a following full frame reproduces REQ-031.
REQ-036 Back-to-back frames:
- Stimulus: start_i held high in the DONE cycle.
- The block goes directly to ACTIVE; the second frame produces 4 correct windows.
